// File: rtl/pixel_fifo.sv
// Packs 8-bit ADC pixel bytes little-endian into 32-bit words and buffers them
// in an inferred synchronous-read RAM for word-wise readout over APB.
module pixel_fifo #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DEPTH        = 512,
  parameter int AFULL_THRESH = 448
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  write_enable,
  input  logic [7:0]            write_data,
  input  logic                  frame_done,
  input  logic                  read_enable,
  output logic [31:0]           read_data,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  afull,
  output logic                  full,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH:0] DepthC = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AfullC = AFULL_THRESH[ADDR_WIDTH:0];

  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           shift_q, shift_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           read_data_q;
  logic                  data_valid_q;

  logic [31:0] merged;
  logic [1:0]  idx_after;
  logic        byte_acc, word_done, pad_req, push, pop;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == DepthC);
  assign afull      = (cnt_q >= AfullC);
  assign word_count = cnt_q;
  assign overflow   = overflow_q;
  assign read_data  = read_data_q;
  assign data_valid = data_valid_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    byte_acc   = write_enable & ~full;
    overflow_d = overflow_q | (write_enable & full);
    merged     = shift_q;
    if (byte_acc) merged[{idx_q, 3'b000} +: 8] = write_data;
    idx_after  = byte_acc ? idx_q + 2'd1 : idx_q;
    word_done  = byte_acc && (idx_q == 2'd3);
    // A word completed by this cycle's byte leaves frame_done nothing to pad.
    pad_req    = frame_done && !word_done && (idx_after != 2'd0);
    push       = word_done | (pad_req & ~full);
    if (pad_req && full) overflow_d = 1'b1;
    pop        = read_enable & ~empty;

    if (word_done || pad_req) begin
      idx_d   = 2'd0;
      shift_d = '0;
    end else begin
      idx_d   = idx_after;
      shift_d = merged;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      idx_q        <= 2'd0;
      shift_q      <= '0;
      overflow_q   <= 1'b0;
      read_data_q  <= '0;
      data_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      overflow_q   <= overflow_d;
      data_valid_q <= pop;
      if (pop) read_data_q <= mem[rd_ptr_q];
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr_q] <= merged;
  end

endmodule

// File: tb/tb_pixel_fifo.sv
// Randomized and directed bench for pixel_fifo, checked every cycle against a
// queue-based model of bytes, words and status flags.
module tb_pixel_fifo;

  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int AFULL = 448;

  logic          clk = 1'b0;
  logic          reset, flush, write_enable, frame_done, read_enable;
  logic [7:0]    write_data;
  logic [31:0]   read_data;
  logic          data_valid, empty, afull, full, overflow;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] words_m[$];
  logic [7:0]  bytes_m[$];
  logic        ovf_m;
  logic [31:0] rd_m;
  logic        dv_m;

  pixel_fifo #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .write_enable(write_enable), .write_data(write_data), .frame_done(frame_done),
    .read_enable(read_enable), .read_data(read_data), .data_valid(data_valid),
    .empty(empty), .afull(afull), .full(full), .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_bytes();
    logic [31:0] w = '0;
    for (int i = 0; i < bytes_m.size(); i++) w[8*i +: 8] = bytes_m[i];
    return w;
  endfunction

  task automatic model_update(bit we, logic [7:0] wd, bit fd, bit re, bit fl, bit rs);
    bit was_full, was_empty;
    if (rs || fl) begin
      words_m.delete();
      bytes_m.delete();
      ovf_m = 1'b0;
      rd_m  = '0;
      dv_m  = 1'b0;
      return;
    end
    was_full  = (words_m.size() == DEPTH);
    was_empty = (words_m.size() == 0);
    dv_m = 1'b0;
    if (re && !was_empty) begin
      rd_m = words_m.pop_front();
      dv_m = 1'b1;
    end
    if (we) begin
      if (was_full) ovf_m = 1'b1;
      else begin
        bytes_m.push_back(wd);
        if (bytes_m.size() == 4) begin
          words_m.push_back(pack_bytes());
          bytes_m.delete();
        end
      end
    end
    if (fd && bytes_m.size() > 0) begin
      if (was_full) ovf_m = 1'b1;
      else words_m.push_back(pack_bytes());
      bytes_m.delete();
    end
  endtask

  task automatic step(bit we, logic [7:0] wd, bit fd, bit re, bit fl = 0, bit rs = 0);
    reset = rs; flush = fl; write_enable = we; write_data = wd;
    frame_done = fd; read_enable = re;
    @(posedge clk);
    model_update(we, wd, fd, re, fl, rs);
    #1;
    check("data_valid", 32'(data_valid), 32'(dv_m));
    check("read_data",  read_data, rd_m);
    check("word_count", 32'(word_count), words_m.size());
    check("empty",      32'(empty), 32'(words_m.size() == 0));
    check("full",       32'(full),  32'(words_m.size() == DEPTH));
    check("afull",      32'(afull), 32'(words_m.size() >= AFULL));
    check("overflow",   32'(overflow), 32'(ovf_m));
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0);
  endtask

  task automatic wr(logic [7:0] b);
    step(1, b, 0, 0);
  endtask

  task automatic wr_n(int n);
    for (int i = 0; i < n; i++) wr(8'($urandom));
  endtask

  task automatic rd_n(int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 1);
  endtask

  initial begin
    reset = 1; flush = 0; write_enable = 0; write_data = 0;
    frame_done = 0; read_enable = 0;
    ovf_m = 0; rd_m = 0; dv_m = 0;

    // Reset state
    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(word_count), 32'd0);

    // Basic little-endian packing
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    idle();
    check("t1_count", 32'(word_count), 32'd1);
    step(0, 8'h00, 0, 1);
    check("t1_valid", 32'(data_valid), 32'd1);
    check("t1_data", read_data, 32'h44332211);
    idle();
    check("t1_valid_drop", 32'(data_valid), 32'd0);

    // Partial word padded by frame_done, then a clean word
    wr(8'hAA); wr(8'hBB);
    step(0, 8'h00, 1, 0);
    check("t2_count", 32'(word_count), 32'd1);
    step(0, 8'h00, 0, 1);
    check("t2_data", read_data, 32'h0000BBAA);
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    step(0, 8'h00, 0, 1);
    check("t2_clean", read_data, 32'h04030201);

    // Fill to full, overflow on one extra byte, drain in order
    step(0, 8'h00, 0, 0, 1);
    wr_n(4 * DEPTH);
    check("t3_full", 32'(full), 32'd1);
    check("t3_afull", 32'(afull), 32'd1);
    wr(8'h5A);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count", 32'(word_count), DEPTH);
    rd_n(DEPTH);
    idle();
    check("t3_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop at index 3, then read while empty
    step(0, 8'h00, 0, 0, 1);
    wr_n(5 * 4 + 3);
    step(1, 8'hC3, 0, 1);
    check("t4_count", 32'(word_count), 32'd5);
    rd_n(5);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    check("t4_empty_read", 32'(data_valid), 32'd0);

    // Flush mid-stream with overflow set and a concurrent byte
    step(0, 8'h00, 0, 0, 1);
    wr_n(4 * DEPTH + 1);
    rd_n(DEPTH - 7);
    wr_n(2);
    step(1, 8'hEE, 0, 0, 1);
    check("t5_count", 32'(word_count), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    step(0, 8'h00, 0, 1);
    check("t5_clean", read_data, 32'hA4A3A2A1);

    // Last byte plus frame_done completes the final word without overflow
    step(0, 8'h00, 0, 0, 1);
    wr_n(4 * (DEPTH - 1) + 3);
    step(1, 8'h77, 1, 0);
    check("t6_full", 32'(full), 32'd1);
    check("t6_no_ovf", 32'(overflow), 32'd0);
    step(0, 8'h00, 1, 0);
    check("t6_fd_noop", 32'(overflow), 32'd0);

    // Randomized phases with varying write/read pressure
    step(0, 8'h00, 0, 0, 1);
    for (int ph = 0; ph < 8; ph++) begin
      int wp = (ph % 2 == 0) ? 90 : 30;
      int rp = (ph % 2 == 0) ? 10 : 70;
      for (int i = 0; i < 1500; i++) begin
        bit we = ($urandom_range(99) < wp);
        bit re = ($urandom_range(99) < rp);
        bit fd = ($urandom_range(99) < 3);
        bit fl = ($urandom_range(999) < 2);
        bit rs = ($urandom_range(1999) < 1);
        step(we, 8'($urandom), fd, re, fl, rs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_fifo.md
Name: pixel_fifo

Overview:
- Buffers and packs 8-bit ADC pixel samples into 32-bit words, which the APB interface reads out.
- Sits between adc_controller (producer, one byte per write strobe) and imager_apb_interface (consumer, one word per read strobe).
- Raises backpressure (full) to the ADC controller.
- Reports empty, almost-full and sticky overflow status to the bus.

Parameters:
- ADDR_WIDTH, 9: word-address width; storage depth is 2^ADDR_WIDTH words.
- DEPTH, 512: storage depth in words; must equal 2^ADDR_WIDTH.
- AFULL_THRESH, 448: word count at or above which afull asserts.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  single-cycle pulse; discards all stored words, any partial word, and overflow.
- write_enable  in  1  byte strobe from adc_controller.
- write_data  in  8  pixel byte.
- frame_done  in  1  single-cycle pulse at end of frame; pushes a partial word padded with zeros.
- read_enable  in  1  word-pop strobe from the APB interface.
- read_data  out  32  popped word.
- data_valid  out  1  high for one cycle when read_data holds a popped word.
- empty  out  1  high when stored word count is 0.
- afull  out  1  high when word count >= AFULL_THRESH.
- full  out  1  high when word count == DEPTH.
- overflow  out  1  sticky flag: a byte or padded word was dropped.
- word_count  out  ADDR_WIDTH+1  number of stored words.

Behaviour:
- Reset:
  - read_data=0, data_valid=0, empty=1, afull=0, full=0, overflow=0, word_count=0.
  - Packer byte index=0, packer shift register=0, read and write pointers=0.
- Priority: reset > flush > all other activity. On flush, state returns to the reset values in the next cycle, and any read or write in the same cycle is ignored.
- Packing:
  - Little-endian: the first byte of a word goes to bits[7:0], the second to [15:8], the third to [23:16], the fourth to [31:24].
  - The byte index counts 0..3.
  - An accepted byte with index 3 pushes the assembled word into storage and wraps the index to 0.
- Write acceptance:
  - A byte is accepted only when full is low; full is evaluated on the registered count.
  - write_enable while full: the byte is dropped, overflow is set, and the packer is unchanged.
  - A byte is dropped if full, even when a read occurs in the same cycle.
  - Bytes 0..2 of a word are also dropped while full. This is deliberate, because adc_controller stalls on full.
- frame_done:
  - If byte index > 0 after considering any same-cycle accepted byte, the partial word is pushed with unused upper bytes = 0, and the index resets to 0.
  - If that same-cycle byte completes the word, the normal push occurs and frame_done has no further effect.
  - If byte index == 0, frame_done is a no-op.
  - If full, the padded word is dropped, overflow is set, and the index still resets to 0.
- Read:
  - read_enable with empty low pops the word at the read pointer.
  - read_data is registered, and data_valid=1 on the next cycle only (read latency 1).
  - read_enable while empty is ignored: data_valid=0 next cycle, read_data holds its last value, no error.
- Count and pointers:
  - Same-cycle push and pop leaves word_count unchanged.
  - Pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
  - empty, full and afull are derived combinationally from the registered word_count; they are valid the cycle after the update.
- overflow clears only on reset or flush.
- Storage is synchronous-read RAM (one read port, one write port); it is inferred, not instantiated.

Test Plan:
1. Reset, then write bytes 0x11,0x22,0x33,0x44 -> word_count=1 and empty=0 two cycles later; read_enable -> data_valid=1 next cycle with read_data=0x44332211.
2. Write 0xAA,0xBB, then frame_done -> one word 0x0000BBAA stored; a subsequent read returns it; byte index is back to 0, so the next 4 bytes form a clean word.
3. Write 4*DEPTH bytes with no reads -> full=1, afull set from word 448 onward; one extra write -> overflow=1, word_count stays 512; reading all 512 words returns the original order, then empty=1.
4. With word_count=5 and the packer at index 3, assert write_enable and read_enable in the same cycle -> word_count stays 5; the popped word is the oldest; read_enable with empty=1 -> data_valid stays 0.
5. Mid-stream (word_count=7, index 2, overflow=1), pulse flush together with write_enable -> next cycle word_count=0, empty=1, overflow=0, index 0; the concurrent byte is discarded.
6. Fill to DEPTH-1 words plus 3 bytes, then assert write_enable and frame_done together -> word pushed, full=1, no overflow; frame_done alone afterwards is a no-op.
